// File: rtl/wave_sched.sv
// rtl/wave_sched.sv - segment table waveform sequencer with tick timebase
//
// Plays a 4-entry table of (waveform select, duration in ticks) segments.
// An entry with duration 0 marks the end of the list.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset (also clears the table)
//   start    level-sampled request to begin sequencing (ignored in RUN)
//   stop     abort request, wins over start and over tick-driven advance
//   loop_en  replay from entry 0 at end of list instead of finishing
//   wr_en    table write strobe, honoured in any state
//   wr_addr  table entry index 0..3
//   wr_data  [9:8] waveform select, [7:0] duration in ticks
//   wave_sel waveform select for the datapath (0 in IDLE)
//   seg_idx  active table entry (0 in IDLE)
//   run      high while sequencing
//   tick     one-cycle timebase pulse, every TICK_DIV+1 cycles in RUN
//   done     one-cycle pulse in the first IDLE cycle after normal completion
module wave_sched #(
   parameter logic [23:0] TICK_DIV = 24'd11999999
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic       loop_en,
   input  logic       wr_en,
   input  logic [1:0] wr_addr,
   input  logic [9:0] wr_data,
   output logic [1:0] wave_sel,
   output logic [1:0] seg_idx,
   output logic       run,
   output logic       tick,
   output logic       done
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t      state, state_n;
   logic [23:0] presc, presc_n;
   logic [7:0]  remaining, remaining_n;
   logic [1:0]  sel_n, idx_n;
   logic        done_n;
   logic [9:0]  tbl [4];

   logic [1:0]  nxt_idx;
   logic [9:0]  nxt_entry;
   logic [9:0]  entry0;

   assign nxt_idx   = seg_idx + 2'd1;
   assign nxt_entry = tbl[nxt_idx];
   assign entry0    = tbl[0];

   assign run  = (state == RUN);
   assign tick = (state == RUN) && (presc == TICK_DIV);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         presc     <= 24'd0;
         remaining <= 8'd0;
         wave_sel  <= 2'd0;
         seg_idx   <= 2'd0;
         done      <= 1'b0;
         for (int i = 0; i < 4; i++) tbl[i] <= 10'd0;
      end else begin
         state     <= state_n;
         presc     <= presc_n;
         remaining <= remaining_n;
         wave_sel  <= sel_n;
         seg_idx   <= idx_n;
         done      <= done_n;
         // Reads above use the pre-edge table, so a write only affects
         // an entry the next time it is loaded.
         if (wr_en) tbl[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      state_n     = state;
      presc_n     = presc;
      remaining_n = remaining;
      sel_n       = wave_sel;
      idx_n       = seg_idx;
      done_n      = 1'b0;

      case (state)
         IDLE: begin
            presc_n = 24'd0;
            sel_n   = 2'd0;
            idx_n   = 2'd0;
            if (start && !stop) begin
               if (entry0[7:0] != 8'd0) begin
                  state_n     = RUN;
                  sel_n       = entry0[9:8];
                  remaining_n = entry0[7:0];
               end else begin
                  done_n = 1'b1;
               end
            end
         end

         RUN: begin
            if (stop) begin
               state_n     = IDLE;
               presc_n     = 24'd0;
               remaining_n = 8'd0;
               sel_n       = 2'd0;
               idx_n       = 2'd0;
            end else begin
               presc_n = tick ? 24'd0 : presc + 24'd1;
               if (tick) begin
                  if (remaining > 8'd1) begin
                     remaining_n = remaining - 8'd1;
                  end else if (seg_idx != 2'd3 && nxt_entry[7:0] != 8'd0) begin
                     idx_n       = nxt_idx;
                     sel_n       = nxt_entry[9:8];
                     remaining_n = nxt_entry[7:0];
                  end else if (loop_en && entry0[7:0] != 8'd0) begin
                     idx_n       = 2'd0;
                     sel_n       = entry0[9:8];
                     remaining_n = entry0[7:0];
                  end else begin
                     state_n     = IDLE;
                     remaining_n = 8'd0;
                     sel_n       = 2'd0;
                     idx_n       = 2'd0;
                     done_n      = 1'b1;
                  end
               end
            end
         end

         default: state_n = IDLE;
      endcase
   end

endmodule

// File: doc/wave_sched.md
WAVE_SCHED -- requirements
Module: wave_sched

Interface
REQ-001 SHALL provide parameter TICK_DIV, default 24'd11999999, meaning timebase tick period minus one, in clk cycles (1 s at 12 MHz).
REQ-002 SHALL provide port clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL provide port start, input, 1, level-sampled request to begin sequencing the segment table.
REQ-005 SHALL provide port stop, input, 1, abort request.
REQ-006 SHALL provide port loop_en, input, 1, replay the table from entry 0 instead of finishing.
REQ-007 SHALL provide port wr_en, input, 1, segment table write strobe.
REQ-008 SHALL provide port wr_addr, input, 2, table entry index 0..3.
REQ-009 SHALL provide port wr_data, input, 10: [9:8] waveform select, [7:0] duration in ticks.
REQ-010 SHALL provide port wave_sel, output, 2, waveform select for the datapath.
REQ-011 SHALL provide port seg_idx, output, 2, active table entry.
REQ-012 SHALL provide port run, output, 1, high while sequencing.
REQ-013 SHALL provide port tick, output, 1, one-cycle timebase pulse.
REQ-014 SHALL provide port done, output, 1, one-cycle completion pulse.

Function
REQ-015 SHALL implement exactly two states: IDLE and RUN.
REQ-016 SHALL hold a 4 x 10-bit table; a wr_en write lands at the clock edge, in any state; a running segment's remaining count is unaffected, and the new value applies when that entry is next loaded.
REQ-017 SHALL keep a 24-bit prescaler at 0 in IDLE and, in RUN, count 0..TICK_DIV, then wrap to 0.
REQ-018 SHALL drive tick high exactly in RUN cycles where the prescaler equals TICK_DIV; tick period = TICK_DIV+1 cycles; tick is never high in IDLE.
REQ-019 SHALL treat an entry with duration 0 as the end-of-list marker.
REQ-020 SHALL, in IDLE with start=1, stop=0, and entry 0 duration nonzero, enter RUN at the next edge with seg_idx=0, wave_sel=entry0 select, remaining=entry0 duration, and prescaler=0.
REQ-021 SHALL, in IDLE with start=1, stop=0, and entry 0 duration 0, stay IDLE and pulse done for one cycle.
REQ-022 SHALL, in RUN on a tick with remaining > 1, decrement remaining.
REQ-023 SHALL, in RUN on a tick with remaining = 1, advance to entry seg_idx+1 when seg_idx < 3 and that entry's duration is nonzero, loading its select and duration.
REQ-024 SHALL otherwise (seg_idx = 3 or next duration 0): with loop_en=1 and entry 0 nonzero, load entry 0; else go to IDLE and assert done in the first IDLE cycle.
REQ-025 SHALL, in RUN with stop=1, go to IDLE at the next edge without a done pulse; stop has priority over a simultaneous tick-driven advance.
REQ-026 SHALL ignore start while in RUN; when start and stop are both high in IDLE, stop wins and the block stays IDLE.
REQ-027 SHALL set wave_sel=0 and seg_idx=0 whenever in IDLE; run=1 exactly in RUN.
REQ-028 SHALL sample loop_en at the end-of-list decision only.
REQ-029 SHALL give the segment change zero latency beyond the tick edge: new wave_sel and seg_idx are visible in the cycle after the tick.

Reset
REQ-030 SHALL on rst=1, immediately and asynchronously: state=IDLE, prescaler=0, remaining=0, wave_sel=0, seg_idx=0, run=0, tick=0, done=0, and all table entries=0.
REQ-031 SHALL, on rst asserted mid-RUN, abort the sequence with no done pulse; the table contents are lost (zeroed).

Verification (TICK_DIV=3)
REQ-032 SHALL check: table {0:(sel1,dur2), 1:(sel2,dur1), 2:dur0}, start pulse -> run high 12 cycles, wave_sel=1 for 8 cycles then 2 for 4, seg_idx 0 then 1, ticks every 4 cycles, done high 1 cycle as run falls.
REQ-033 SHALL check: same table with loop_en=1 -> wave_sel pattern 1,1(8 cycles),2(4 cycles) repeats 3 times with no done; clearing loop_en -> done after the current pass.
REQ-034 SHALL check: stop asserted in cycle 5 of RUN -> run=0 and wave_sel=0 next cycle, done stays 0, prescaler restarts at 0 on the next start.
REQ-035 SHALL check: entry 0 duration 0 with start -> run stays 0, done pulses once.
REQ-036 SHALL check: all four entries nonzero (dur 1 each) -> seg_idx 0,1,2,3, then end after 16 cycles (seg_idx=3 wrap-around terminates).
REQ-037 SHALL check: rst asserted mid-RUN between edges -> all outputs 0 immediately; a subsequent start with the zeroed table gives a done pulse only.
